// File: rtl/pipe_pkg.sv
// pipe_pkg
// Shared definitions for the pipelined processor stages.
//   CTRL_W_DEFAULT   default width of the decoded control bundle
//   CTRL_*           bit positions inside the control bundle
//   REG_ZERO         index of the hard-wired zero register
//   upd_e            what the ID/EX register does on a given clock edge
package pipe_pkg;

  localparam int CTRL_W_DEFAULT = 8;

  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMREAD  = 1;
  localparam int CTRL_MEMWRITE = 2;
  localparam int CTRL_ALUSRC   = 3;
  localparam int CTRL_ALUOP_LO = 4;
  localparam int CTRL_ALUOP_HI = 7;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Mutually exclusive per-edge actions of the ID/EX register, already
  // resolved in priority order (flush > hold > bubble > load).
  typedef enum logic [1:0] {
    UPD_LOAD   = 2'd0,
    UPD_FLUSH  = 2'd1,
    UPD_HOLD   = 2'd2,
    UPD_BUBBLE = 2'd3
  } upd_e;

endpackage

// File: rtl/hazard_detect.sv
// hazard_detect
// Combinational load-use hazard detection. A load sitting in EX whose
// destination is read by the instruction in ID forces one bubble.
// Ports:
//   id_valid, id_rs, id_rt   instruction currently in ID
//   ex_valid, ex_memread,    instruction currently in EX
//   ex_rd
//   ex_stall                 downstream back-pressure
//   luh                      load-use hazard this cycle
//   stall_id                 hold PC and IF/ID this cycle
module hazard_detect
  import pipe_pkg::*;
(
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       ex_valid,
  input  logic       ex_memread,
  input  logic [4:0] ex_rd,
  input  logic       ex_stall,
  output logic       luh,
  output logic       stall_id
);

  // A load targeting register 0 produces nothing anyone can depend on.
  assign luh = id_valid && ex_valid && ex_memread && (ex_rd != REG_ZERO) &&
               ((ex_rd == id_rs) || (ex_rd == id_rt));

  assign stall_id = luh || ex_stall;

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage
// ID/EX pipeline stage. Selects operands (write-through bypass of the
// same-cycle writeback, register 0 forced to zero), detects load-use
// hazards, and registers the instruction into the ID/EX register.
// Ports:
//   clk, rst                 clock (rising edge), async active-low reset
//   id_*                     instruction, operands and control from ID
//   wb_regwrite/wb_rd/wb_data  register-file write happening this cycle
//   flush                    kill the instruction entering EX
//   ex_stall                 EX cannot accept; hold ID/EX
//   stall_id                 hold PC and IF/ID
//   ex_*                     ID/EX register contents feeding EX
//   bubble_cnt               saturating count of load-use bubbles
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = CTRL_W_DEFAULT,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic [DATA_W-1:0] id_rdata1,
  input  logic [DATA_W-1:0] id_rdata2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              wb_regwrite,
  input  logic [4:0]        wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  input  logic              ex_stall,
  output logic              stall_id,
  output logic              ex_valid,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd,
  output logic [DATA_W-1:0] ex_op1,
  output logic [DATA_W-1:0] ex_op2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic              luh;
  logic [DATA_W-1:0] op1;
  logic [DATA_W-1:0] op2;
  upd_e              upd;

  hazard_detect u_hazard (
    .id_valid   (id_valid),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .ex_valid   (ex_valid),
    .ex_memread (ex_ctrl[CTRL_MEMREAD]),
    .ex_rd      (ex_rd),
    .ex_stall   (ex_stall),
    .luh        (luh),
    .stall_id   (stall_id)
  );

  // The register file writes on the edge but reads combinationally, so a
  // value being written this cycle is not yet visible on its read ports.
  // Register 0 is never initialised in the array, so it is forced here,
  // which also keeps an unknown read value from leaking into EX.
  always_comb begin
    op1 = id_rdata1;
    if (id_rs == REG_ZERO) begin
      op1 = '0;
    end else if (wb_regwrite && (wb_rd != REG_ZERO) && (wb_rd == id_rs)) begin
      op1 = wb_data;
    end
  end

  always_comb begin
    op2 = id_rdata2;
    if (id_rt == REG_ZERO) begin
      op2 = '0;
    end else if (wb_regwrite && (wb_rd != REG_ZERO) && (wb_rd == id_rt)) begin
      op2 = wb_data;
    end
  end

  // Resolve the edge action once; a redirect must kill the EX entry even
  // while EX is back-pressuring, so flush outranks the hold.
  always_comb begin
    upd = UPD_LOAD;
    if (flush) begin
      upd = UPD_FLUSH;
    end else if (ex_stall) begin
      upd = UPD_HOLD;
    end else if (luh) begin
      upd = UPD_BUBBLE;
    end
  end

  // ID/EX register. On flush and bubble only valid and control are
  // cleared; the data fields are don't-care once valid drops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid   <= 1'b0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_rd      <= '0;
      ex_op1     <= '0;
      ex_op2     <= '0;
      ex_imm     <= '0;
      ex_ctrl    <= '0;
      bubble_cnt <= '0;
    end else begin
      case (upd)
        UPD_FLUSH: begin
          ex_valid <= 1'b0;
          ex_ctrl  <= '0;
        end
        UPD_HOLD: begin
        end
        UPD_BUBBLE: begin
          ex_valid <= 1'b0;
          ex_ctrl  <= '0;
          if (bubble_cnt != {CNT_W{1'b1}}) begin
            bubble_cnt <= bubble_cnt + CNT_W'(1);
          end
        end
        default: begin
          ex_valid <= id_valid;
          ex_rs    <= id_rs;
          ex_rt    <= id_rt;
          ex_rd    <= id_rd;
          ex_op1   <= op1;
          ex_op2   <= op2;
          ex_imm   <= id_imm;
          ex_ctrl  <= id_valid ? id_ctrl : '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage
// Self-checking bench for id_ex_stage: a behavioural model of the stage is
// compared against the DUT on every falling edge, and directed scenarios
// add hand-computed literal checks. A second instance with a 4-bit counter
// exercises saturation in a short run.
module tb_id_ex_stage;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 8;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_rdata1, id_rdata2, id_imm;
  logic [7:0]  id_ctrl;
  logic        wb_regwrite;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flush, ex_stall;

  logic        stall_id, ex_valid;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [31:0] ex_op1, ex_op2, ex_imm;
  logic [7:0]  ex_ctrl;
  logic [15:0] bubble_cnt;

  logic        s_stall_id, s_ex_valid;
  logic [4:0]  s_ex_rs, s_ex_rt, s_ex_rd;
  logic [31:0] s_ex_op1, s_ex_op2, s_ex_imm;
  logic [7:0]  s_ex_ctrl;
  logic [3:0]  s_bubble_cnt;

  int checks = 0;
  int errors = 0;

  id_ex_stage #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
    .id_ctrl(id_ctrl), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush), .ex_stall(ex_stall), .stall_id(stall_id), .ex_valid(ex_valid),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_op1(ex_op1), .ex_op2(ex_op2),
    .ex_imm(ex_imm), .ex_ctrl(ex_ctrl), .bubble_cnt(bubble_cnt)
  );

  id_ex_stage #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
    .id_ctrl(id_ctrl), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush), .ex_stall(ex_stall), .stall_id(s_stall_id), .ex_valid(s_ex_valid),
    .ex_rs(s_ex_rs), .ex_rt(s_ex_rt), .ex_rd(s_ex_rd), .ex_op1(s_ex_op1),
    .ex_op2(s_ex_op2), .ex_imm(s_ex_imm), .ex_ctrl(s_ex_ctrl),
    .bubble_cnt(s_bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model of the ID/EX register contents, expressed as the stage's rules.
  logic        m_valid;
  logic [4:0]  m_rs, m_rt, m_rd;
  logic [31:0] m_op1, m_op2, m_imm;
  logic [7:0]  m_ctrl;
  int          m_cnt;

  function automatic logic [31:0] readOperand(input logic [4:0] r, input logic [31:0] rf);
    if (r == 5'd0) return 32'd0;
    if (wb_regwrite && wb_rd != 5'd0 && wb_rd == r) return wb_data;
    return rf;
  endfunction

  function automatic logic modelLoadUse();
    return id_valid && m_valid && m_ctrl[1] && m_rd != 5'd0 &&
           (m_rd == id_rs || m_rd == id_rt);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_valid <= 1'b0; m_rs <= '0; m_rt <= '0; m_rd <= '0;
      m_op1 <= '0; m_op2 <= '0; m_imm <= '0; m_ctrl <= '0; m_cnt <= 0;
    end else if (flush) begin
      m_valid <= 1'b0; m_ctrl <= '0;
    end else if (ex_stall) begin
      m_valid <= m_valid;
    end else if (modelLoadUse()) begin
      m_valid <= 1'b0; m_ctrl <= '0; m_cnt <= m_cnt + 1;
    end else begin
      m_valid <= id_valid;
      m_rs <= id_rs; m_rt <= id_rt; m_rd <= id_rd;
      m_op1 <= readOperand(id_rs, id_rdata1);
      m_op2 <= readOperand(id_rt, id_rdata2);
      m_imm <= id_imm;
      m_ctrl <= id_valid ? id_ctrl : 8'd0;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Compare process: registered outputs and stall_id against the model.
  always @(negedge clk) begin
    checkOutput("m_valid", 64'(ex_valid), 64'(m_valid));
    checkOutput("m_ctrl", 64'(ex_ctrl), 64'(m_ctrl));
    checkOutput("m_stall_id", 64'(stall_id), 64'(modelLoadUse() || ex_stall));
    checkOutput("m_bubble_cnt", 64'(bubble_cnt), 64'((m_cnt > 65535) ? 65535 : m_cnt));
    checkOutput("m_sat_cnt", 64'(s_bubble_cnt), 64'((m_cnt > 15) ? 15 : m_cnt));
    if (m_valid) begin
      checkOutput("m_rs", 64'(ex_rs), 64'(m_rs));
      checkOutput("m_rt", 64'(ex_rt), 64'(m_rt));
      checkOutput("m_rd", 64'(ex_rd), 64'(m_rd));
      checkOutput("m_op1", 64'(ex_op1), 64'(m_op1));
      checkOutput("m_op2", 64'(ex_op2), 64'(m_op2));
      checkOutput("m_imm", 64'(ex_imm), 64'(m_imm));
    end
  end

  task automatic applyStimulus(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] rd, input logic [31:0] d1,
                               input logic [31:0] d2, input logic [31:0] imm,
                               input logic [7:0] ctrl, input logic wbw,
                               input logic [4:0] wbrd, input logic [31:0] wbd,
                               input logic fl, input logic st);
    id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
    id_rdata1 = d1; id_rdata2 = d2; id_imm = imm; id_ctrl = ctrl;
    wb_regwrite = wbw; wb_rd = wbrd; wb_data = wbd;
    flush = fl; ex_stall = st;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_valid"}, 64'(ex_valid), 64'd0);
    checkOutput({tag, "_rs"}, 64'(ex_rs), 64'd0);
    checkOutput({tag, "_rt"}, 64'(ex_rt), 64'd0);
    checkOutput({tag, "_rd"}, 64'(ex_rd), 64'd0);
    checkOutput({tag, "_op1"}, 64'(ex_op1), 64'd0);
    checkOutput({tag, "_op2"}, 64'(ex_op2), 64'd0);
    checkOutput({tag, "_imm"}, 64'(ex_imm), 64'd0);
    checkOutput({tag, "_ctrl"}, 64'(ex_ctrl), 64'd0);
    checkOutput({tag, "_cnt"}, 64'(bubble_cnt), 64'd0);
    checkOutput({tag, "_sat_cnt"}, 64'(s_bubble_cnt), 64'd0);
  endtask

  initial begin
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0);
    step();
    step();
    checkAllZero("reset");
    rst = 1'b1;

    // Write-through bypass on rs, then disabled by wb_rd == 0.
    applyStimulus(1, 5, 6, 8, 32'd50, 32'd60, 32'd4, 8'h01, 1, 5, 32'hDEAD, 0, 0);
    step();
    checkOutput("bypass_op1", 64'(ex_op1), 64'h0000_DEAD);
    checkOutput("bypass_op2", 64'(ex_op2), 64'd60);
    checkOutput("bypass_valid", 64'(ex_valid), 64'd1);
    applyStimulus(1, 5, 6, 8, 32'd50, 32'd60, 32'd4, 8'h01, 1, 0, 32'hDEAD, 0, 0);
    step();
    checkOutput("nobypass_wb0", 64'(ex_op1), 64'd50);
    applyStimulus(1, 5, 6, 8, 32'd50, 32'd60, 32'd4, 8'h01, 1, 6, 32'hBEEF, 0, 0);
    step();
    checkOutput("bypass_op2_rt", 64'(ex_op2), 64'h0000_BEEF);
    checkOutput("bypass_op1_other", 64'(ex_op1), 64'd50);

    // Register 0 reads as zero even when the array returns unknown data.
    applyStimulus(1, 0, 0, 3, 32'hxxxx_xxxx, 32'hxxxx_xxxx, 32'd9, 8'h01, 0, 0, 0, 0, 0);
    step();
    checkOutput("reg0_op1", 64'(ex_op1), 64'd0);
    checkOutput("reg0_op2", 64'(ex_op2), 64'd0);

    // Load-use: load r7 in EX, dependent instruction reads r7 via rt.
    applyStimulus(1, 1, 2, 7, 32'd11, 32'd22, 32'd0, 8'h02, 0, 0, 0, 0, 0);
    step();
    applyStimulus(1, 3, 7, 9, 32'd33, 32'd44, 32'd0, 8'h01, 0, 0, 0, 0, 0);
    #2;
    checkOutput("luh_stall_id", 64'(stall_id), 64'd1);
    step();
    checkOutput("luh_bubble_valid", 64'(ex_valid), 64'd0);
    checkOutput("luh_bubble_ctrl", 64'(ex_ctrl), 64'd0);
    checkOutput("luh_bubble_cnt", 64'(bubble_cnt), 64'd1);
    checkOutput("luh_stall_released", 64'(stall_id), 64'd0);
    step();
    checkOutput("luh_advance_valid", 64'(ex_valid), 64'd1);
    checkOutput("luh_advance_rt", 64'(ex_rt), 64'd7);
    checkOutput("luh_advance_op2", 64'(ex_op2), 64'd44);

    // flush wins over ex_stall.
    applyStimulus(1, 4, 5, 10, 32'd1, 32'd2, 32'd3, 8'h31, 0, 0, 0, 1, 1);
    step();
    checkOutput("flush_valid", 64'(ex_valid), 64'd0);
    checkOutput("flush_ctrl", 64'(ex_ctrl), 64'd0);

    // ex_stall alone for 3 cycles holds ID/EX.
    applyStimulus(1, 4, 5, 10, 32'd100, 32'd200, 32'd300, 8'h19, 0, 0, 0, 0, 0);
    step();
    applyStimulus(1, 6, 7, 11, 32'd1, 32'd1, 32'd1, 8'hFF, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      #2;
      checkOutput("stall_stall_id", 64'(stall_id), 64'd1);
      step();
      checkOutput("stall_hold_op1", 64'(ex_op1), 64'd100);
      checkOutput("stall_hold_ctrl", 64'(ex_ctrl), 64'h19);
      checkOutput("stall_hold_rd", 64'(ex_rd), 64'd10);
    end

    // Two more load-use events to reach bubble_cnt == 3.
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1, 1, 2, 7, 32'd11, 32'd22, 32'd0, 8'h02, 0, 0, 0, 0, 0);
      step();
      applyStimulus(1, 7, 3, 9, 32'd33, 32'd44, 32'd0, 8'h01, 0, 0, 0, 0, 0);
      step();
      step();
    end
    checkOutput("pre_reset_cnt", 64'(bubble_cnt), 64'd3);
    checkOutput("pre_reset_valid", 64'(ex_valid), 64'd1);

    // Asynchronous reset between edges.
    #2;
    rst = 1'b0;
    #1;
    checkAllZero("midreset");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0);
    step();
    rst = 1'b1;

    // Back-to-back dependent loads: one bubble every second edge.
    applyStimulus(1, 7, 7, 7, 32'd5, 32'd5, 32'd0, 8'h02, 0, 0, 0, 0, 0);
    for (int i = 0; i < 40; i++) step();
    checkOutput("sat_main_cnt", 64'(bubble_cnt), 64'd20);
    checkOutput("sat_small_cnt", 64'(s_bubble_cnt), 64'hF);

    applyStimulus(0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0);
    step();
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
